jtcps1_bank_arb: RTL

JTCPS1_BANK_ARB -- requirements
Module: jtcps1_bank_arb

---
 rtl/jtcps1_bank_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/jtcps1_bank_arb.sv
// Four-bank SDRAM arbiter: one command channel shared by bank requests and periodic refresh.
// Define JTCPS1_BANK_RR_EN for round-robin arbitration; default is fixed priority 3 > 0 > 1 > 2.
module jtcps1_bank_arb #(
    parameter logic [7:0]  RFSH_PERIOD = 8'd64,
    parameter int unsigned AW          = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          refresh_en,
    input  logic          ba0_rd,
    input  logic          ba0_wr,
    input  logic          ba1_rd,
    input  logic          ba2_rd,
    input  logic          ba3_rd,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic          ba0_ack,
    output logic          ba1_ack,
    output logic          ba2_ack,
    output logic          ba3_ack,
    output logic          ba0_rdy,
    output logic          ba1_rdy,
    output logic          ba2_rdy,
    output logic          ba3_rdy,
    output logic          sdram_req,
    output logic [1:0]    sdram_ba,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_wr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_mask,
    output logic          sdram_rfsh,
    input  logic          sdram_busy,
    input  logic          sdram_done
);

    typedef enum logic [1:0] {StIdle, StIssue, StRfsh, StWait} state_t;

    state_t        state_q, state_d;
    logic [1:0]    bank_q, bank_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [15:0]   din_q, din_d;
    logic [1:0]    mask_q, mask_d;
    logic          rfsh_op_q, rfsh_op_d;
    logic [3:0]    ack_q, ack_d;
    logic [3:0]    rdy_q, rdy_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [3:0]    req;
    logic          gnt_any;
    logic [1:0]    gnt_bank;
    logic [AW-1:0] gnt_addr;
    logic          rfsh_go;
    logic          grant;

    assign req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
    assign rfsh_go = (state_q == StIdle) && (cnt_q == 8'd0) && refresh_en;
    assign grant   = (state_q == StIdle) && !rfsh_go && gnt_any;

`ifdef JTCPS1_BANK_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] rr_idx;

    // ptr_q is the first bank searched, i.e. the one after the last grant
    always_comb begin
        gnt_any  = 1'b0;
        gnt_bank = ptr_q;
        rr_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            rr_idx = ptr_q + 2'(i);
            if (!gnt_any && req[rr_idx]) begin
                gnt_any  = 1'b1;
                gnt_bank = rr_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) ptr_d = gnt_bank + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= 2'd0;
        else      ptr_q <= ptr_d;
    end
`else
    always_comb begin
        gnt_any  = |req;
        gnt_bank = 2'd2;
        if (req[3])      gnt_bank = 2'd3;
        else if (req[0]) gnt_bank = 2'd0;
        else if (req[1]) gnt_bank = 2'd1;
    end
`endif

    always_comb begin
        gnt_addr = ba0_addr;
        unique case (gnt_bank)
            2'd0: gnt_addr = ba0_addr;
            2'd1: gnt_addr = ba1_addr;
            2'd2: gnt_addr = ba2_addr;
            2'd3: gnt_addr = ba3_addr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        din_d     = din_q;
        mask_d    = mask_q;
        rfsh_op_d = rfsh_op_q;
        ack_d     = 4'd0;
        rdy_d     = 4'd0;
        cnt_d     = cnt_q;
        if (refresh_en && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;

        unique case (state_q)
            StIdle: begin
                if (rfsh_go) begin
                    state_d   = StRfsh;
                    rfsh_op_d = 1'b1;
                end else if (grant) begin
                    state_d          = StIssue;
                    rfsh_op_d        = 1'b0;
                    bank_d           = gnt_bank;
                    addr_d           = gnt_addr;
                    wr_d             = (gnt_bank == 2'd0) && ba0_wr;
                    din_d            = ba0_din;
                    mask_d           = ba0_din_m;
                    ack_d[gnt_bank]  = 1'b1;
                end
            end
            StIssue: begin
                if (sdram_busy) state_d = StWait;
            end
            StRfsh: begin
                if (sdram_busy) begin
                    state_d = StWait;
                    cnt_d   = RFSH_PERIOD;
                end
            end
            StWait: begin
                if (sdram_done) begin
                    state_d = StIdle;
                    if (!rfsh_op_q) rdy_d[bank_q] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            bank_q    <= 2'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            din_q     <= 16'd0;
            mask_q    <= 2'b11;
            rfsh_op_q <= 1'b0;
            ack_q     <= 4'd0;
            rdy_q     <= 4'd0;
            cnt_q     <= RFSH_PERIOD;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            din_q     <= din_d;
            mask_q    <= mask_d;
            rfsh_op_q <= rfsh_op_d;
            ack_q     <= ack_d;
            rdy_q     <= rdy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sdram_req  = (state_q == StIssue);
    assign sdram_rfsh = (state_q == StRfsh);
    assign sdram_ba   = bank_q;
    assign sdram_addr = addr_q;
    assign sdram_wr   = wr_q;
    assign sdram_din  = din_q;
    assign sdram_mask = mask_q;

    assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack_q;
    assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy_q;

endmodule
